// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: commit-stage exception/ERET sequencer that strobes CP0, flushes the pipeline, then hands a redirect PC to fetch.
// Optional build macro CP0_EXC_STATS_EN adds a 32-bit exc_count output counting exception entries.
module cp0_exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hbfc00380,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic        mem_bd,
  input  logic        ex_adel_if,
  input  logic        ex_ri,
  input  logic        ex_sys,
  input  logic        ex_bp,
  input  logic        ex_ov,
  input  logic        ex_adel_d,
  input  logic        ex_ades_d,
  input  logic [31:0] mem_badvaddr,
  input  logic        mem_eret,
  input  logic        int_pending,
  input  logic        status_exl,
  input  logic [31:0] epc_in,
  input  logic        redirect_ready,
  output logic        exc_o,
  output logic        ret_o,
  output logic [4:0]  exc_code,
  output logic [31:0] exc_epc,
  output logic        exc_bd,
  output logic [31:0] exc_badvaddr,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
`ifdef CP0_EXC_STATS_EN
  output logic [31:0] exc_count,
`endif
  output logic        busy
);

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_REDIR = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        take_int;
  logic        take_exc;
  logic        sample;
  logic        enter_exc;
  logic        enter_ret;
  logic [4:0]  sel_code;
  logic [31:0] sel_badvaddr;
  logic [31:0] sel_epc;

  assign take_int  = int_pending & ~status_exl;
  assign take_exc  = take_int | ex_adel_if | ex_ri | ex_sys | ex_bp | ex_ov
                   | ex_adel_d | ex_ades_d;
  assign sample    = (state_q == ST_IDLE) & mem_valid;
  assign enter_exc = sample & take_exc;
  assign enter_ret = sample & mem_eret & ~take_exc;

  // Only the winning cause decides BadVAddr; lower-priority address faults are masked.
  // NOTE: every always_comb output is defaulted first so no path can infer a latch.
  always_comb begin
    sel_code     = EXC_INT;
    sel_badvaddr = '0;
    if (take_int) begin
      sel_code = EXC_INT;
    end else if (ex_adel_if) begin
      sel_code     = EXC_ADEL;
      sel_badvaddr = mem_pc;
    end else if (ex_ri) begin
      sel_code = EXC_RI;
    end else if (ex_sys) begin
      sel_code = EXC_SYS;
    end else if (ex_bp) begin
      sel_code = EXC_BP;
    end else if (ex_ov) begin
      sel_code = EXC_OV;
    end else if (ex_adel_d) begin
      sel_code     = EXC_ADEL;
      sel_badvaddr = mem_badvaddr;
    end else if (ex_ades_d) begin
      sel_code     = EXC_ADES;
      sel_badvaddr = mem_badvaddr;
    end
  end

  // A delay-slot instruction restarts at its branch, one word earlier.
  assign sel_epc = mem_bd ? (mem_pc - 32'd4) : mem_pc;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (enter_exc || enter_ret) begin
          state_d = ST_FLUSH;
          cnt_d   = FLUSH_LOAD;
        end
      end
      ST_FLUSH: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = ST_REDIR;
        end
      end
      ST_REDIR: begin
        if (redirect_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: the held CP0 fields are reset too, since they are visible outputs that must read 0 after reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      exc_o        <= 1'b0;
      ret_o        <= 1'b0;
      exc_code     <= '0;
      exc_epc      <= '0;
      exc_bd       <= 1'b0;
      exc_badvaddr <= '0;
      redirect_pc  <= '0;
    end else begin
      exc_o <= enter_exc;
      ret_o <= enter_ret;
      if (enter_exc) begin
        exc_code     <= sel_code;
        exc_epc      <= sel_epc;
        exc_bd       <= mem_bd;
        exc_badvaddr <= sel_badvaddr;
        redirect_pc  <= EXC_VECTOR;
      end else if (enter_ret) begin
        redirect_pc  <= epc_in;
      end
    end
  end

`ifdef CP0_EXC_STATS_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      exc_count <= '0;
    end else if (enter_exc) begin
      exc_count <= exc_count + 32'd1;
    end
  end
`endif

  assign busy           = (state_q != ST_IDLE);
  assign flush          = (state_q == ST_FLUSH) || (state_q == ST_REDIR);
  assign redirect_valid = (state_q == ST_REDIR);

  a_one_strobe: assert property (@(posedge clk) disable iff (!rstn) !(exc_o && ret_o));
  a_pc_stable:  assert property (@(posedge clk) disable iff (!rstn)
                  (redirect_valid && !redirect_ready) |=> $stable(redirect_pc));

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// tb_cp0_exc_ctrl: directed bench with a cycle-count reference model checked every cycle plus literal spot checks.
// Define CP0_EXC_STATS_EN for both bench and RTL to cover exc_count.
module tb_cp0_exc_ctrl;

  localparam logic [31:0] VEC = 32'hbfc00380;
  localparam int unsigned FC  = 2;

  logic        clk = 1'b0;
  logic        rstn;
  logic        mem_valid, mem_bd, ex_adel_if, ex_ri, ex_sys, ex_bp, ex_ov;
  logic        ex_adel_d, ex_ades_d, mem_eret, int_pending, status_exl, redirect_ready;
  logic [31:0] mem_pc, mem_badvaddr, epc_in;
  logic        exc_o, ret_o, exc_bd, flush, redirect_valid, busy;
  logic [4:0]  exc_code;
  logic [31:0] exc_epc, exc_badvaddr, redirect_pc;
`ifdef CP0_EXC_STATS_EN
  logic [31:0] exc_count;
`endif

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en   = 1'b0;

  cp0_exc_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rstn(rstn), .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_bd(mem_bd),
    .ex_adel_if(ex_adel_if), .ex_ri(ex_ri), .ex_sys(ex_sys), .ex_bp(ex_bp), .ex_ov(ex_ov),
    .ex_adel_d(ex_adel_d), .ex_ades_d(ex_ades_d), .mem_badvaddr(mem_badvaddr),
    .mem_eret(mem_eret), .int_pending(int_pending), .status_exl(status_exl),
    .epc_in(epc_in), .redirect_ready(redirect_ready), .exc_o(exc_o), .ret_o(ret_o),
    .exc_code(exc_code), .exc_epc(exc_epc), .exc_bd(exc_bd), .exc_badvaddr(exc_badvaddr),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
`ifdef CP0_EXC_STATS_EN
    .exc_count(exc_count),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an entry is remembered by its edge number, and every output follows
  // from how many edges have elapsed since then.
  int unsigned cyc = 0;
  bit          m_active = 1'b0;
  bit          m_is_exc = 1'b0;
  int unsigned m_entry = 0;
  logic [4:0]  m_code = '0;
  logic [31:0] m_epc = '0, m_bad = '0, m_rpc = '0, m_cnt = '0;
  logic        m_bd = 1'b0;

  localparam logic [4:0] CODES [8] = '{5'd0, 5'd4, 5'd10, 5'd8, 5'd9, 5'd12, 5'd4, 5'd5};

  always @(posedge clk) begin : model
    logic [7:0] fl;
    int         hit;
    cyc <= cyc + 1;
    if (!rstn) begin
      m_active <= 1'b0; m_code <= '0; m_epc <= '0; m_bad <= '0;
      m_rpc <= '0; m_bd <= 1'b0; m_cnt <= '0;
    end else if (m_active) begin
      if ((cyc - m_entry) >= FC + 1 && redirect_ready) m_active <= 1'b0;
    end else if (mem_valid) begin
      fl  = {ex_ades_d, ex_adel_d, ex_ov, ex_bp, ex_sys, ex_ri, ex_adel_if,
             int_pending & ~status_exl};
      hit = -1;
      for (int i = 0; i < 8; i++) if (fl[i] && hit < 0) hit = i;
      if (hit >= 0) begin
        m_active <= 1'b1; m_entry <= cyc; m_is_exc <= 1'b1;
        m_code   <= CODES[hit];
        m_bd     <= mem_bd;
        m_epc    <= mem_bd ? mem_pc - 32'd4 : mem_pc;
        m_bad    <= (hit == 1) ? mem_pc : (hit >= 6) ? mem_badvaddr : 32'd0;
        m_rpc    <= VEC;
        m_cnt    <= m_cnt + 32'd1;
      end else if (mem_eret) begin
        m_active <= 1'b1; m_entry <= cyc; m_is_exc <= 1'b0;
        m_rpc    <= epc_in;
      end
    end
  end

  always @(negedge clk) begin : compare
    int unsigned k;
    if (mon_en) begin
      k = cyc - m_entry;
      check("exc_o",  exc_o,  m_active && m_is_exc && k == 1);
      check("ret_o",  ret_o,  m_active && !m_is_exc && k == 1);
      check("exc_code", exc_code, m_code);
      check("exc_epc", exc_epc, m_epc);
      check("exc_bd", exc_bd, m_bd);
      check("exc_badvaddr", exc_badvaddr, m_bad);
      check("flush", flush, m_active);
      check("busy", busy, m_active);
      check("redirect_valid", redirect_valid, m_active && k >= FC + 1);
      check("redirect_pc", redirect_pc, m_rpc);
`ifdef CP0_EXC_STATS_EN
      check("exc_count", exc_count, m_cnt);
`endif
    end
  end

  task automatic clear();
    mem_valid = 0; mem_pc = '0; mem_bd = 0; ex_adel_if = 0; ex_ri = 0; ex_sys = 0;
    ex_bp = 0; ex_ov = 0; ex_adel_d = 0; ex_ades_d = 0; mem_badvaddr = '0;
    mem_eret = 0; int_pending = 0; status_exl = 0; epc_in = '0;
  endtask

  task automatic wait_redir();
    int n = 0;
    while (redirect_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (redirect_valid !== 1'b1) check("redir_timeout", redirect_valid, 1);
  endtask

  // Waits for the redirect, holds ready low for `hold` cycles, then completes the handshake.
  task automatic accept(input int hold);
    wait_redir();
    repeat (hold) @(negedge clk);
    redirect_ready = 1'b1;
    @(posedge clk); #1;
    redirect_ready = 1'b0;
  endtask

  task automatic launch();
    @(posedge clk); #1;
    clear();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    clear();
    rstn = 1'b0;
    redirect_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_redirect_pc", redirect_pc, 0);

    // Overflow, not in a delay slot
    @(posedge clk); #1;
    mem_valid = 1; ex_ov = 1; mem_pc = 32'h80001000;
    launch();
    @(negedge clk);
    check("ov_exc_o", exc_o, 1);
    check("ov_code", exc_code, 12);
    check("ov_epc", exc_epc, 32'h80001000);
    check("ov_bad", exc_badvaddr, 0);
    check("ov_flush1", flush, 1);
    @(negedge clk);
    check("ov_flush2", flush, 1);
    check("ov_rv_early", redirect_valid, 0);
    @(negedge clk);
    check("ov_rv", redirect_valid, 1);
    check("ov_rpc", redirect_pc, 32'hbfc00380);
    accept(0);
    @(negedge clk);
    check("ov_idle", busy, 0);

    // Store address error in a delay slot
    @(posedge clk); #1;
    mem_valid = 1; ex_ades_d = 1; mem_bd = 1; mem_pc = 32'h80002004; mem_badvaddr = 32'h13;
    launch();
    @(negedge clk);
    check("ades_code", exc_code, 5);
    check("ades_bd", exc_bd, 1);
    check("ades_epc", exc_epc, 32'h80002000);
    check("ades_bad", exc_badvaddr, 32'h13);
    accept(0);

    // Interrupt beats syscall; presented the first cycle back in IDLE
    mem_valid = 1; int_pending = 1; status_exl = 0; ex_sys = 1; mem_pc = 32'h80004000;
    launch();
    @(negedge clk);
    check("int_code", exc_code, 0);
    accept(0);

    // Masked interrupt leaves the syscall; ready held high across FLUSH and REDIR
    mem_valid = 1; int_pending = 1; status_exl = 1; ex_sys = 1; mem_pc = 32'h80004010;
    launch();
    @(negedge clk);
    check("exl_code", exc_code, 8);
    redirect_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("ready_hi_rv", redirect_valid, 1);
    @(negedge clk);
    check("ready_hi_one_cycle", redirect_valid, 0);
    redirect_ready = 1'b0;

    // ERET with a stalled fetch
    @(posedge clk); #1;
    mem_valid = 1; mem_eret = 1; epc_in = 32'h80003000; mem_pc = 32'h80002ff0;
    launch();
    @(negedge clk);
    check("eret_ret_o", ret_o, 1);
    check("eret_exc_o", exc_o, 0);
    check("eret_code_held", exc_code, 8);
    wait_redir();
    repeat (5) @(negedge clk);
    check("eret_rv_hold", redirect_valid, 1);
    check("eret_rpc", redirect_pc, 32'h80003000);
    accept(0);
    @(negedge clk);
    check("eret_idle", busy, 0);

    // Exception and ERET together: exception wins
    @(posedge clk); #1;
    mem_valid = 1; mem_eret = 1; ex_adel_if = 1; mem_pc = 32'h80000001; epc_in = 32'h80005000;
    launch();
    @(negedge clk);
    check("adelif_exc_o", exc_o, 1);
    check("adelif_ret_o", ret_o, 0);
    check("adelif_code", exc_code, 4);
    check("adelif_bad", exc_badvaddr, 32'h80000001);
    accept(1);

    // Reset during REDIR
    @(posedge clk); #1;
    mem_valid = 1; ex_bp = 1; mem_pc = 32'h80006000;
    launch();
    wait_redir();
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    check("rstmid_busy", busy, 0);
    check("rstmid_rv", redirect_valid, 0);
    check("rstmid_code", exc_code, 0);
    check("rstmid_epc", exc_epc, 0);
    check("rstmid_rpc", redirect_pc, 0);
    @(negedge clk);
    check("rstmid_no_strobe", exc_o, 0);

    // Three exceptions and one ERET
    @(posedge clk); #1;
    mem_valid = 1; ex_ri = 1; ex_ov = 1; ex_ades_d = 1; mem_pc = 32'h80007000;
    launch();
    @(negedge clk);
    check("multi_code", exc_code, 10);
    accept(0);
    mem_valid = 1; mem_eret = 1; epc_in = 32'h80007100;
    launch();
    accept(0);
    mem_valid = 1; ex_adel_d = 1; mem_pc = 32'h80007200; mem_badvaddr = 32'h00001002;
    launch();
    @(negedge clk);
    check("adeld_code", exc_code, 4);
    check("adeld_bad", exc_badvaddr, 32'h00001002);
    accept(0);
    mem_valid = 1; ex_ov = 1; mem_pc = 32'h80007300;
    launch();
    accept(2);
    @(negedge clk);
`ifdef CP0_EXC_STATS_EN
    check("stats_count", exc_count, 3);
`endif
    check("final_idle", busy, 0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
